// File: rtl/press_if.sv
// Gesture bundle between the debounced button level and the game control logic.
// master drives the button level and receives events; slave is the classifier side.
interface press_if;
  logic clean;
  logic tap;
  logic dtap;
  logic hold;
  logic rpt;
  logic busy;

  modport master (output clean, input tap, dtap, hold, rpt, busy);
  modport slave  (input clean, output tap, dtap, hold, rpt, busy);
endinterface

// File: rtl/press_classifier.sv
// Turns the debounced button level into single-cycle tap / double-tap / hold / repeat pulses.
// Define PRESS_AUTOREPEAT_EN to enable periodic rpt pulses while a long hold continues.
module press_classifier #(
  parameter int CW            = 4,
  parameter int LONG_CYCLES   = 8,
  parameter int GAP_CYCLES    = 4,
  parameter int REPEAT_CYCLES = 3
) (
  input  logic   clk,
  input  logic   rst,
  press_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  // Reject configurations where the counter could wrap before its compare fires.
  if (LONG_CYCLES < 2 || GAP_CYCLES < 2 || REPEAT_CYCLES < 2 ||
      LONG_CYCLES > (1 << CW) || GAP_CYCLES > (1 << CW) ||
      REPEAT_CYCLES > (1 << CW)) begin : g_bad_params
    $error("press_classifier: cycle parameters out of range for CW");
  end

  state_t        state_p1, state_p0;
  logic [CW-1:0] cnt_p1, cnt_p0;
  logic          tap_p1, dtap_p1, hold_p1, rpt_p1, busy_p1;
  logic          tap_p0, dtap_p0, hold_p0, rpt_p0;

  always_comb begin
    state_p0 = state_p1;
    cnt_p0   = cnt_p1;
    tap_p0   = 1'b0;
    dtap_p0  = 1'b0;
    hold_p0  = 1'b0;
    rpt_p0   = 1'b0;
    case (state_p1)
      IDLE: begin
        cnt_p0 = '0;
        if (bus.clean) state_p0 = PRESS1;
      end
      PRESS1: begin
        if (!bus.clean) begin
          state_p0 = WAIT2;
          cnt_p0   = '0;
        end else if (cnt_p1 == LONG_LAST) begin
          state_p0 = LONG;
          hold_p0  = 1'b1;
          cnt_p0   = '0;
        end else begin
          cnt_p0 = cnt_p1 + 1'b1;
        end
      end
      WAIT2: begin
        // A rise on the expiry edge is still a double tap.
        if (bus.clean) begin
          state_p0 = PRESS2;
          dtap_p0  = 1'b1;
          cnt_p0   = '0;
        end else if (cnt_p1 == GAP_LAST) begin
          state_p0 = IDLE;
          tap_p0   = 1'b1;
        end else begin
          cnt_p0 = cnt_p1 + 1'b1;
        end
      end
      PRESS2: begin
        if (!bus.clean) state_p0 = IDLE;
      end
      LONG: begin
        if (!bus.clean) begin
          state_p0 = IDLE;
        end else begin
`ifdef PRESS_AUTOREPEAT_EN
          if (cnt_p1 == CW'(REPEAT_CYCLES - 1)) begin
            rpt_p0 = 1'b1;
            cnt_p0 = '0;
          end else begin
            cnt_p0 = cnt_p1 + 1'b1;
          end
`else
          cnt_p0 = '0;
`endif
        end
      end
      default: begin
        state_p0 = IDLE;
        cnt_p0   = '0;
      end
    endcase
  end

  // Registered state, counter and event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1 <= IDLE;
      cnt_p1   <= '0;
      tap_p1   <= 1'b0;
      dtap_p1  <= 1'b0;
      hold_p1  <= 1'b0;
      rpt_p1   <= 1'b0;
      busy_p1  <= 1'b0;
    end else begin
      state_p1 <= state_p0;
      cnt_p1   <= cnt_p0;
      tap_p1   <= tap_p0;
      dtap_p1  <= dtap_p0;
      hold_p1  <= hold_p0;
      rpt_p1   <= rpt_p0;
      busy_p1  <= (state_p0 != IDLE);
    end
  end

  assign bus.tap  = tap_p1;
  assign bus.dtap = dtap_p1;
  assign bus.hold = hold_p1;
  assign bus.rpt  = rpt_p1;
  assign bus.busy = busy_p1;

endmodule

// File: tb/tb_press_classifier.sv
// Directed and randomized gesture sequences for press_classifier, checked against a
// timestamp-based model of the gesture rules.
module tb_press_classifier;

  localparam int CW   = 4;
  localparam int LONG = 8;
  localparam int GAP  = 4;
  localparam int REP  = 3;
`ifdef PRESS_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  press_if bus ();

  press_classifier #(
    .CW(CW), .LONG_CYCLES(LONG), .GAP_CYCLES(GAP), .REPEAT_CYCLES(REP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: a gesture is described by the edge indices at which it started,
  // released, and went long, rather than by any counter.
  int n = 0;
  int t_press = -1;
  int t_rel = -1;
  int t_hold = -1;
  bit second = 1'b0;
  bit e_tap, e_dtap, e_hold, e_rpt, e_busy;

  task automatic model_clear();
    t_press = -1;
    t_rel   = -1;
    t_hold  = -1;
    second  = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    e_tap = 0; e_dtap = 0; e_hold = 0; e_rpt = 0; e_busy = 0;
  endtask

  task automatic model_edge(input bit c);
    n++;
    e_tap = 0; e_dtap = 0; e_hold = 0; e_rpt = 0;
    if (t_press < 0) begin
      if (c) t_press = n;
    end else if (t_hold >= 0) begin
      if (!c) model_clear();
      else if (AUTOREP && ((n - t_hold) % REP) == 0) e_rpt = 1;
    end else if (second) begin
      if (!c) model_clear();
    end else if (t_rel >= 0) begin
      if (c) begin
        second = 1'b1;
        e_dtap = 1;
      end else if (n - t_rel == GAP) begin
        e_tap = 1;
        model_clear();
      end
    end else begin
      if (!c) t_rel = n;
      else if (n - t_press == LONG) begin
        e_hold = 1;
        t_hold = n;
      end
    end
    e_busy = (t_press >= 0);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s at t=%0t: observed %b expected %b", tag, $time, obs, exp);
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".tap"},  bus.tap,  e_tap);
    chk({where, ".dtap"}, bus.dtap, e_dtap);
    chk({where, ".hold"}, bus.hold, e_hold);
    chk({where, ".rpt"},  bus.rpt,  e_rpt);
    chk({where, ".busy"}, bus.busy, e_busy);
    chk({where, ".onehot"},
        ($countones({bus.tap, bus.dtap, bus.hold, bus.rpt}) <= 1), 1'b1);
  endtask

  task automatic step(input bit c, input string where);
    bus.clean = c;
    @(posedge clk);
    model_edge(c);
    #1;
    check_outputs(where);
  endtask

  task automatic press(input int hi, input int lo, input string where);
    for (int i = 0; i < hi; i++) step(1'b1, where);
    for (int i = 0; i < lo; i++) step(1'b0, where);
  endtask

  // Asynchronous reset mid-cycle, held for two edges, released with the given clean level.
  task automatic async_reset(input bit clean_at_release, input string where);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs({where, ".async"});
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_outputs({where, ".inrst"});
    end
    bus.clean = clean_at_release;
    #3 rst = 1'b0;
  endtask

  initial begin
    bus.clean = 1'b0;
    model_reset();
    #3;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, "idle");
    step(1'b0, "idle");

    // Short press: three high samples then idle long enough for tap.
    press(3, 7, "short");

    // Double tap inside the gap, then on the gap-expiry edge.
    press(2, 2, "dtap");
    press(3, 6, "dtap2");
    press(2, GAP, "gapedge");
    press(2, 6, "gapedge2");

    // Long hold with repeats, then release.
    press(21, 4, "long");

    // Press length boundary around LONG.
    press(LONG, 6, "bnd_tap");
    press(LONG + 1, 6, "bnd_hold");

    // Reset while waiting for the second press: no tap may follow.
    press(2, 2, "rst_w2");
    async_reset(1'b0, "rst_w2");
    press(0, 7, "rst_notap");

    // Reset released with the button already down: next edge enters the first press.
    press(1, 1, "rst_hi");
    async_reset(1'b1, "rst_hi");
    press(2, 7, "rst_hi_after");

    // Randomized gestures.
    for (int s = 0; s < 60; s++) begin
      press(int'($urandom_range(1, 14)), int'($urandom_range(1, 7)), "rand");
    end
    press(0, 8, "tail");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
